dmem_responder: RTL and testbench

- Data-memory responder: the memory-side end of the CPU data-memory port.
- Accepts one load/store request at a time from the initiator and applies a configurable number of wait states.
- Performs byte/half/word lane selection, load sign/zero extension and store byte-enables.
- Returns a one-cycle good (or error) response; sits between the core's data-memory port and the on-chip RAM array, which is internal.

---
 rtl/dmem_responder_if.sv | 24 ++
 rtl/dmem_responder.sv | 157 +++++++++++++++
 tb/tb_dmem_responder.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/dmem_responder_if.sv
// Data-memory port between a core's load/store unit and the memory-side responder.
interface dmem_responder_if;
  logic        valid;
  logic [31:0] addr;
  logic [31:0] writeData;
  logic        memRead;
  logic        memWrite;
  logic [1:0]  maskMode;
  logic        sext;
  logic [31:0] readData;
  logic        good;
  logic        error;
  logic        busy;

  modport master (
    output valid, addr, writeData, memRead, memWrite, maskMode, sext,
    input  readData, good, error, busy
  );

  modport slave (
    input  valid, addr, writeData, memRead, memWrite, maskMode, sext,
    output readData, good, error, busy
  );
endinterface

// File: rtl/dmem_responder.sv
// Memory-side data-port responder: serialized load/store with fixed wait states,
// byte/half/word lane handling and a one-cycle good/error response.
module dmem_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned LATENCY     = 2
) (
  input  logic              clk,
  input  logic              reset,
  dmem_responder_if.slave   bus
);

  localparam int unsigned AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [AW+1:0] addr_q;
  logic [31:0]   wdata_q;
  logic [1:0]    mask_q;
  logic          sext_q, wr_q, err_q;
  logic [31:0]   rdata_q, rdata_d;

  logic [31:0]   mem [DEPTH_WORDS];

  logic          req, req_err, enter_resp, mem_we;
  // Current operation: live inputs while idle (LATENCY=1 responds on the accept edge).
  logic [AW+1:0] cur_addr;
  logic [31:0]   cur_wdata;
  logic [1:0]    cur_mask;
  logic          cur_sext, cur_wr, cur_err;
  logic [31:0]   word, shifted, ld_val, wr_rep;
  logic [7:0]    ld_byte;
  logic [15:0]   ld_half;
  logic [3:0]    be;

  assign req     = bus.valid & (bus.memRead | bus.memWrite);
  assign req_err = (bus.memRead & bus.memWrite)
                 | (bus.maskMode == 2'b11)
                 | ((bus.maskMode == 2'b01) & bus.addr[0])
                 | ((bus.maskMode == 2'b10) & (bus.addr[1:0] != 2'b00))
                 | ({2'b00, bus.addr[31:2]} >= DEPTH_WORDS);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    enter_resp = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (req) begin
          if (LATENCY <= 1) begin
            state_d    = StResp;
            enter_resp = 1'b1;
          end else begin
            state_d = StWait;
            cnt_d   = 4'(LATENCY - 1);
          end
        end
      end
      StWait: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d    = StResp;
          enter_resp = 1'b1;
        end
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    if (state_q == StIdle) begin
      cur_addr  = bus.addr[AW+1:0];
      cur_wdata = bus.writeData;
      cur_mask  = bus.maskMode;
      cur_sext  = bus.sext;
      cur_wr    = bus.memWrite;
      cur_err   = req_err;
    end else begin
      cur_addr  = addr_q;
      cur_wdata = wdata_q;
      cur_mask  = mask_q;
      cur_sext  = sext_q;
      cur_wr    = wr_q;
      cur_err   = err_q;
    end
  end

  always_comb begin
    word    = mem[cur_addr[AW+1:2]];
    shifted = word >> {cur_addr[1:0], 3'b000};
    ld_byte = shifted[7:0];
    ld_half = cur_addr[1] ? word[31:16] : word[15:0];
    be      = 4'b0000;
    wr_rep  = cur_wdata;
    ld_val  = word;
    case (cur_mask)
      2'b00: begin
        ld_val = {{24{cur_sext & ld_byte[7]}}, ld_byte};
        be[cur_addr[1:0]] = 1'b1;
        wr_rep = {4{cur_wdata[7:0]}};
      end
      2'b01: begin
        ld_val = {{16{cur_sext & ld_half[15]}}, ld_half};
        be     = cur_addr[1] ? 4'b1100 : 4'b0011;
        wr_rep = {2{cur_wdata[15:0]}};
      end
      default: be = 4'b1111;
    endcase
    rdata_d = rdata_q;
    if (enter_resp) rdata_d = (cur_err | cur_wr) ? 32'h0 : ld_val;
  end

  // Gated by reset so a held-low reset can never commit a store.
  assign mem_we = enter_resp & cur_wr & ~cur_err & reset;

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[cur_addr[AW+1:2]][8*i +: 8] <= wr_rep[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
      addr_q  <= '0;
      wdata_q <= 32'h0;
      mask_q  <= 2'b00;
      sext_q  <= 1'b0;
      wr_q    <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= 32'h0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      if ((state_q == StIdle) && req) begin
        addr_q  <= bus.addr[AW+1:0];
        wdata_q <= bus.writeData;
        mask_q  <= bus.maskMode;
        sext_q  <= bus.sext;
        wr_q    <= bus.memWrite;
        err_q   <= req_err;
      end
    end
  end

  assign bus.readData = rdata_q;
  assign bus.good     = (state_q == StResp) & ~err_q;
  assign bus.error    = (state_q == StResp) & err_q;
  assign bus.busy     = (state_q != StIdle);

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: expected responses are queued at issue time
// and checked against the DUT response, including its latency in clock edges.
module tb_dmem_responder;

  localparam int unsigned DEPTH = 1024;
  localparam int unsigned LAT   = 2;

  typedef struct {
    logic        good;
    logic        err;
    logic [31:0] rdata;
  } exp_t;

  logic clk;
  logic reset;
  int   tests;
  int   fails;
  exp_t sb[$];

  dmem_responder_if bus ();

  dmem_responder #(
    .DEPTH_WORDS (DEPTH),
    .LATENCY     (LAT)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issues one request, waits (bounded) for its response, compares against the queue.
  task automatic txn(input string tag, input logic rd, input logic wr, input logic [1:0] mm,
                     input logic [31:0] a, input logic [31:0] wd, input logic sx,
                     input logic eg, input logic ee, input logic [31:0] er,
                     input bit scramble, input bit hold);
    exp_t e;
    int   n;
    sb.push_back('{good: eg, err: ee, rdata: er});
    bus.valid     = 1'b1;
    bus.memRead   = rd;
    bus.memWrite  = wr;
    bus.maskMode  = mm;
    bus.addr      = a;
    bus.writeData = wd;
    bus.sext      = sx;
    @(posedge clk);
    #1;
    n = 1;
    if (!hold) bus.valid = 1'b0;
    if (scramble) begin
      bus.addr      = 32'h44;
      bus.writeData = 32'h0;
      bus.maskMode  = 2'b00;
      bus.sext      = 1'b1;
    end
    while (!(bus.good | bus.error) && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    e = sb.pop_front();
    check({tag, " good"},  32'(bus.good),  32'(e.good));
    check({tag, " error"}, 32'(bus.error), 32'(e.err));
    check({tag, " rdata"}, bus.readData,   e.rdata);
    check({tag, " lat"},   32'(n),         32'(LAT));
    check({tag, " busy"},  32'(bus.busy),  32'd1);
    if (hold) begin
      @(posedge clk);
      #1;
      bus.valid = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    tests = 0;
    fails = 0;
    reset = 1'b0;
    bus.valid     = 1'b0;
    bus.memRead   = 1'b0;
    bus.memWrite  = 1'b0;
    bus.maskMode  = 2'b10;
    bus.addr      = 32'h0;
    bus.writeData = 32'h0;
    bus.sext      = 1'b0;
    #12;
    check("rst rdata", bus.readData, 32'h0);
    check("rst good",  32'(bus.good),  32'd0);
    check("rst error", 32'(bus.error), 32'd0);
    check("rst busy",  32'(bus.busy),  32'd0);
    #11 reset = 1'b1;
    @(posedge clk);
    #1;

    // rd wr mode addr wdata sext | good err rdata
    txn("st w 10",  0, 1, 2'b10, 32'h10, 32'hDEADBEEF, 0, 1, 0, 32'h0, 0, 0);
    txn("ld w 10",  1, 0, 2'b10, 32'h10, 32'h0,        0, 1, 0, 32'hDEADBEEF, 0, 0);
    txn("st w 20",  0, 1, 2'b10, 32'h20, 32'h11223344, 0, 1, 0, 32'h0, 0, 0);
    txn("st b 21",  0, 1, 2'b00, 32'h21, 32'hFFFFFFAA, 0, 1, 0, 32'h0, 0, 0);
    txn("ld w 20a", 1, 0, 2'b10, 32'h20, 32'h0,        0, 1, 0, 32'h1122AA44, 0, 0);
    txn("ld bs 21", 1, 0, 2'b00, 32'h21, 32'h0,        1, 1, 0, 32'hFFFFFFAA, 0, 0);
    txn("ld bz 21", 1, 0, 2'b00, 32'h21, 32'h0,        0, 1, 0, 32'h000000AA, 0, 0);
    txn("st h 22",  0, 1, 2'b01, 32'h22, 32'h12348001, 0, 1, 0, 32'h0, 0, 0);
    txn("ld w 20b", 1, 0, 2'b10, 32'h20, 32'h0,        0, 1, 0, 32'h8001AA44, 0, 0);
    txn("ld hs 22", 1, 0, 2'b01, 32'h22, 32'h0,        1, 1, 0, 32'hFFFF8001, 0, 0);
    txn("ld hz 22", 1, 0, 2'b01, 32'h22, 32'h0,        0, 1, 0, 32'h00008001, 0, 0);

    txn("err h 23",   1, 0, 2'b01, 32'h23, 32'h0,        0, 0, 1, 32'h0, 0, 0);
    txn("err st w21", 0, 1, 2'b10, 32'h21, 32'h0BADBAD0, 0, 0, 1, 32'h0, 0, 0);
    txn("ld w 20c",   1, 0, 2'b10, 32'h20, 32'h0,        0, 1, 0, 32'h8001AA44, 0, 0);
    txn("err rdwr",   1, 1, 2'b10, 32'h10, 32'h0,        0, 0, 1, 32'h0, 0, 0);
    txn("err mask",   1, 0, 2'b11, 32'h10, 32'h0,        0, 0, 1, 32'h0, 0, 0);
    txn("err range",  1, 0, 2'b10, DEPTH * 4, 32'h0,     0, 0, 1, 32'h0, 0, 0);

    // Inputs scrambled during WAIT: the latched word store to 0x40 must win.
    txn("st w 40 scr", 0, 1, 2'b10, 32'h40, 32'h12345678, 0, 1, 0, 32'h0, 1, 0);
    txn("ld w 40",     1, 0, 2'b10, 32'h40, 32'h0,        0, 1, 0, 32'h12345678, 0, 0);

    // valid held through RESP: exactly one access, no follow-on request.
    txn("st w 50 hold", 0, 1, 2'b10, 32'h50, 32'hA5A5A5A5, 0, 1, 0, 32'h0, 0, 1);
    for (int i = 0; i < 3; i++) begin
      check("post hold busy", 32'(bus.busy), 32'd0);
      check("post hold good", 32'(bus.good), 32'd0);
      @(posedge clk);
      #1;
    end

    // valid with no operation is not a request.
    bus.valid    = 1'b1;
    bus.memRead  = 1'b0;
    bus.memWrite = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check("noop busy", 32'(bus.busy), 32'd0);
    end
    bus.valid = 1'b0;

    // Reset during WAIT cancels the pending store.
    txn("st w 30", 0, 1, 2'b10, 32'h30, 32'hCAFEF00D, 0, 1, 0, 32'h0, 0, 0);
    txn("ld w 10b", 1, 0, 2'b10, 32'h10, 32'h0,       0, 1, 0, 32'hDEADBEEF, 0, 0);
    bus.valid     = 1'b1;
    bus.memRead   = 1'b0;
    bus.memWrite  = 1'b1;
    bus.maskMode  = 2'b10;
    bus.addr      = 32'h30;
    bus.writeData = 32'h00000055;
    @(posedge clk);
    #1;
    bus.valid = 1'b0;
    check("mid busy pre", 32'(bus.busy), 32'd1);
    reset = 1'b0;
    #1;
    check("mid rst busy",  32'(bus.busy),  32'd0);
    check("mid rst good",  32'(bus.good),  32'd0);
    check("mid rst error", 32'(bus.error), 32'd0);
    check("mid rst rdata", bus.readData,   32'h0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    txn("ld w 30", 1, 0, 2'b10, 32'h30, 32'h0, 0, 1, 0, 32'hCAFEF00D, 0, 0);

    check("sb empty", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
